// File: rtl/parking_pin_entry.sv
// rtl/parking_pin_entry.sv - keypad PIN collector and gate-controller handshake
module parking_pin_entry #(
  parameter int ACK_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  input  logic        open_gate,
  input  logic        close_gate,
  input  logic        blocked_gate,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic [1:0]  wrong_count,
  output logic        busy,
  output logic        locked
);

  localparam int AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT    = 3'd2,
    S_GRANTED = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ack_cnt;
  logic [TW-1:0] to_cnt;

  // Enter is judged against the digit count held before this cycle's key.
  logic full;
  logic digit_ok;
  logic enter_go;
  logic ack_done;
  logic to_done;

  assign full     = (digit_count == 3'd4);
  assign digit_ok = key_valid && (key_digit <= 4'd9) && !full;
  assign enter_go = key_enter && !key_clear && full;
  assign ack_done = (ack_cnt == '0);
  assign to_done  = (to_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a lockout request preempts every other transition
  always_comb begin
    state_nxt = state;
    if (blocked_gate) begin
      state_nxt = S_LOCKED;
    end else begin
      case (state)
        S_IDLE:    if (enter_go) state_nxt = S_SEND;
        S_SEND:    if (ack_done) state_nxt = S_WAIT;
        S_WAIT: begin
          if (open_gate)    state_nxt = S_GRANTED;
          else if (to_done) state_nxt = S_IDLE;
        end
        S_GRANTED: if (close_gate) state_nxt = S_IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Datapath: digit buffer, handshake counters, retry counter, error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      code        <= '0;
      digit_count <= '0;
      wrong_count <= '0;
      entry_error <= 1'b0;
      ack_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      entry_error <= 1'b0;
      if (!blocked_gate) begin
        case (state)
          S_IDLE: begin
            ack_cnt <= AW'(ACK_CYCLES - 1);
            if (key_clear) begin
              code        <= '0;
              digit_count <= '0;
            end else begin
              if (key_valid) begin
                if (digit_ok) begin
                  code        <= {code[11:0], key_digit};
                  digit_count <= digit_count + 3'd1;
                end else begin
                  entry_error <= 1'b1;
                end
              end
              // A short entry discards everything, including a digit taken this cycle.
              if (key_enter && !full) begin
                entry_error <= 1'b1;
                code        <= '0;
                digit_count <= '0;
              end
            end
          end
          S_SEND: begin
            if (ack_done) to_cnt  <= TW'(RESP_TIMEOUT - 1);
            else          ack_cnt <= ack_cnt - AW'(1);
          end
          S_WAIT: begin
            if (open_gate) begin
              wrong_count <= '0;
            end else if (to_done) begin
              if (wrong_count != 2'd3) wrong_count <= wrong_count + 2'd1;
              code        <= '0;
              digit_count <= '0;
            end else begin
              to_cnt <= to_cnt - TW'(1);
            end
          end
          S_GRANTED: begin
            if (close_gate) begin
              code        <= '0;
              digit_count <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State-decoded outputs
  always_comb begin
    code_ack = (state == S_SEND);
    busy     = (state != S_IDLE);
    locked   = (state == S_LOCKED);
  end

endmodule

// File: doc/parking_pin_entry.md
Name: parking_pin_entry

Overview:
- Keypad-side PIN terminal for the parking gate controller. It collects four BCD keypad digits and packs them MSB-first into a 16-bit code.
- It presents the code to the gate controller with a timed `code_ack` strobe, then tracks the controller's response (`open_gate`, `close_gate`, `blocked_gate`).
- It sits between the keypad scanner and the gate controller's `code`/`code_ack` inputs.

Parameters:
- ACK_CYCLES, 2, number of cycles `code_ack` stays high per submission (>=1).
- RESP_TIMEOUT, 8, cycles after `code_ack` falls without `open_gate` before the attempt counts as rejected (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle strobe: `key_digit` is valid.
- key_digit  input  4  BCD digit 0-9; values A-F are illegal.
- key_clear  input  1  one-cycle strobe: discard the partial entry.
- key_enter  input  1  one-cycle strobe: submit the entry.
- open_gate  input  1  controller accepted the PIN (level).
- close_gate  input  1  controller closing pulse (vehicle gone).
- blocked_gate  input  1  controller locked out (level).
- code  output  16  packed PIN to the controller.
- code_ack  output  1  code-valid strobe to the controller.
- digit_count  output  3  digits currently buffered (0-4).
- entry_error  output  1  one-cycle pulse flagging a rejected keypad action.
- wrong_count  output  2  saturating count of rejected submissions.
- busy  output  1  high when not in IDLE.
- locked  output  1  high in LOCKED.

Behaviour:
- All flops update on the rising edge of `clk`. Reset is synchronous and active-high: `rst` sampled high at a `clk` rising edge resets the block.
- Reset values:
  - state = IDLE.
  - code = 16'h0000, digit_count = 0, wrong_count = 0.
  - code_ack = 0, entry_error = 0, busy = 0, locked = 0.
- `rst` overrides everything, including mid-SEND: `code_ack` drops on the next edge.
- Packing: each accepted digit is written as code <= {code[11:0], key_digit}. The first digit ends up in [15:12] after four digits, so keys 2,4,6,8 give 16'h2468. `code` is a registered output and is stable throughout SEND.
- IDLE (entry):
  - key_valid with digit<=9 and count<4: shift in, count+1.
  - key_valid with digit>9, or with count==4: no change, entry_error pulses 1 cycle.
  - key_clear: code=0, count=0. Clear wins over a simultaneous key_valid or key_enter.
  - key_enter with count==4 -> SEND, ack counter loaded.
  - key_enter with count<4: entry_error pulse, code=0, count=0.
  - key_valid together with key_enter: the digit is processed first; enter then sees the updated count in the next cycle only. The enter on that cycle is treated as if it arrived with the old count.
- SEND: `code_ack`=1 for exactly ACK_CYCLES consecutive cycles, then -> WAIT_RESP with `code_ack`=0 and the timeout counter loaded. The first cycle of `code_ack` is the edge after the `key_enter` cycle.
- WAIT_RESP:
  - open_gate=1 -> GRANTED; wrong_count=0.
  - Timeout expires after RESP_TIMEOUT cycles -> IDLE; wrong_count+1, saturating at 3; code=0, count=0.
- GRANTED: wait for close_gate=1 -> IDLE with code=0, count=0.
- LOCKED:
  - Entered from any state when blocked_gate=1, checked before all other transitions.
  - `code_ack` forced to 0 and all keypad strobes ignored.
  - Exit only via `rst`.
- Keypad strobes in SEND, WAIT_RESP or GRANTED are ignored silently, with no entry_error.
- Outputs:
  - busy = (state != IDLE).
  - locked = (state == LOCKED).
  - digit_count reflects the register value.

Test Plan:
- Reset, then keys 2,4,6,8 and enter: code=16'h2468 and code_ack high for exactly 2 cycles starting the cycle after enter. Drive open_gate -> busy held, wrong_count=0. Then close_gate pulse -> IDLE, digit_count=0.
- Keys 1,2,3,4, enter, no open_gate: after ack + 8 cycles return to IDLE with wrong_count=1. Repeat three more times: wrong_count saturates at 3.
- Illegal and boundary keys: digit 4'hB -> entry_error pulse, count unchanged; a fifth digit -> entry_error; enter after 2 digits -> entry_error, count=0, code=0.
- key_clear asserted in the same cycle as key_valid(5) after 3 digits: count=0, code=0, no entry_error.
- blocked_gate raised during WAIT_RESP: locked=1 next cycle. Full-digit entry plus enter produces no code_ack. `rst` then returns all outputs to their reset values.
- `rst` asserted on the first code_ack cycle: code_ack=0, code=0 and state IDLE on the following edge.
